// File: rtl/board_manager.sv
// Board manager for a 4x4 gravity game: accepts column moves, keeps per-player
// occupancy masks and column heights, detects line wins and draws.
module board_manager (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_new_game,
  input  logic        i_add,
  input  logic [1:0]  i_c_register,
  input  logic [4:0]  i_column_position,
  output logic [2:0]  o_counter_0,
  output logic [2:0]  o_counter_1,
  output logic [2:0]  o_counter_2,
  output logic [2:0]  o_counter_3,
  output logic [15:0] o_board_p0,
  output logic [15:0] o_board_p1,
  output logic        o_current_player,
  output logic        o_move_done,
  output logic        o_move_err,
  output logic        o_game_over,
  output logic [1:0]  o_winner
);

  typedef enum logic [1:0] {IDLE, COMMIT, CHECK, DONE} state_t;

  // Winning lines: four rows, four columns and the two diagonals.
  localparam logic [9:0][15:0] LINES = {
    16'h000F, 16'h00F0, 16'h0F00, 16'hF000,
    16'h1111, 16'h2222, 16'h4444, 16'h8888,
    16'h8421, 16'h1248
  };

  state_t      r_state;
  state_t      w_next;
  logic        r_add_d;
  logic        w_req;
  logic [1:0]  r_req_col;
  logic [4:0]  r_req_pos;
  logic [2:0]  r_cnt [4];
  logic [15:0] r_p0;
  logic [15:0] r_p1;
  logic        r_player;
  logic        r_done;
  logic        r_err;
  logic        r_over;
  logic [1:0]  r_winner;
  logic [2:0]  w_sel_cnt;
  logic [15:0] w_occupied;
  logic [15:0] w_mover_mask;
  logic        w_valid;
  logic        w_win;
  logic        w_full;

  // A request is the rising edge of add against its registered copy.
  assign w_req = i_add & ~r_add_d;

  // Move validation, win detection and draw detection for the current state.
  always_comb begin
    w_sel_cnt    = r_cnt[r_req_col];
    w_occupied   = r_p0 | r_p1;
    w_mover_mask = r_player ? r_p1 : r_p0;
    w_valid      = (r_req_pos != 5'b11111) && !r_req_pos[4] &&
                   (r_req_pos[1:0] == r_req_col) &&
                   (r_req_pos[4:2] == w_sel_cnt) &&
                   !w_occupied[r_req_pos[3:0]];
    w_win        = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if ((w_mover_mask & LINES[i]) == LINES[i]) w_win = 1'b1;
    end
    w_full       = (r_cnt[0] == 3'd4) && (r_cnt[1] == 3'd4) &&
                   (r_cnt[2] == 3'd4) && (r_cnt[3] == 3'd4);
  end

  // Next-state selection; a new-game request always returns to IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_req && !r_over) w_next = COMMIT;
      COMMIT:  w_next = w_valid ? CHECK : IDLE;
      CHECK:   w_next = (w_win || w_full) ? DONE : IDLE;
      DONE:    w_next = DONE;
      default: w_next = IDLE;
    endcase
    if (i_new_game) w_next = IDLE;
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Board, counters, player turn, result flags and the one-cycle status pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_add_d   <= 1'b0;
      r_req_col <= 2'd0;
      r_req_pos <= 5'd0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= 3'd0;
      r_p0      <= 16'h0000;
      r_p1      <= 16'h0000;
      r_player  <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_over    <= 1'b0;
      r_winner  <= 2'b00;
    end else begin
      r_add_d <= i_add;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      if (i_new_game) begin
        r_req_col <= 2'd0;
        r_req_pos <= 5'd0;
        for (int i = 0; i < 4; i++) r_cnt[i] <= 3'd0;
        r_p0      <= 16'h0000;
        r_p1      <= 16'h0000;
        r_player  <= 1'b0;
        r_over    <= 1'b0;
        r_winner  <= 2'b00;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_req && !r_over) begin
              r_req_col <= i_c_register;
              r_req_pos <= i_column_position;
            end
          end
          COMMIT: begin
            if (w_valid) begin
              if (r_player) r_p1[r_req_pos[3:0]] <= 1'b1;
              else          r_p0[r_req_pos[3:0]] <= 1'b1;
              r_cnt[r_req_col] <= w_sel_cnt + 3'd1;
              r_done <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
          CHECK: begin
            if (w_win) begin
              r_winner <= r_player ? 2'b10 : 2'b01;
              r_over   <= 1'b1;
            end else if (w_full) begin
              r_winner <= 2'b11;
              r_over   <= 1'b1;
            end else begin
              r_player <= ~r_player;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_counter_0      = r_cnt[0];
  assign o_counter_1      = r_cnt[1];
  assign o_counter_2      = r_cnt[2];
  assign o_counter_3      = r_cnt[3];
  assign o_board_p0       = r_p0;
  assign o_board_p1       = r_p1;
  assign o_current_player = r_player;
  assign o_move_done      = r_done;
  assign o_move_err       = r_err;
  assign o_game_over      = r_over;
  assign o_winner         = r_winner;

endmodule
